accum_drain: RTL and testbench

Readout stage downstream of the accumulator memory: after a computation finishes, it walks a range of accumulator rows, issues one full-width read per row over the accumulator command/data channels, and serializes the 4×64-bit row into a 64-bit output stream for CPU or post-processing. Each row can optionally be cleared (overwritten with zero) after it is read, leaving the accumulator ready for the next job. It acts as the Master on both accumulator channels.

---
 rtl/accum_drain.sv | 194 +++++++++++++++++++
 tb/tb_accum_drain.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_drain.sv
// ---------------------------------------------------------------------------
// accum_drain
// Walks a range of accumulator rows after a job. For each row it issues one
// full-width read, optionally overwrites the row with zero, and streams the
// NUM_BANKS words of the row out one per beat, bank 0 first.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               job request, sampled only while idle
//   base_addr_i           first row of the job
//   num_rows_i            rows to drain (0 .. 2^ADDR_WIDTH)
//   clear_en_i            zero each row after it has been read
//   busy_o, done_o        job in progress / one-cycle completion pulse
//   cmd_*                 accumulator command channel (master)
//   wvalid_o, wready_i,
//   wdata_o               accumulator write-data channel (always zero data)
//   rvalid_i, rdata_i     accumulator read return, bank b at [b*DATA_WIDTH +: DATA_WIDTH]
//   out_*                 output word stream, out_last_o on the job's final beat
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for start_i
// S_RD_CMD  | read command for the current row offered
// S_RD_WAIT | waiting for the read data, captured into buf_q
// S_CLR     | zero-write command and write data offered, each until taken
// S_SEND    | streaming buf_q one word per beat
// S_DONE    | one-cycle done pulse
// ---------------------------------------------------------------------------
module accum_drain #(
    parameter int NUM_BANKS  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic [ADDR_WIDTH-1:0]           base_addr_i,
    input  logic [ADDR_WIDTH:0]             num_rows_i,
    input  logic                            clear_en_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            cmd_valid_o,
    input  logic                            cmd_ready_i,
    output logic                            cmd_rw_o,
    output logic                            cmd_accum_en_o,
    output logic [NUM_BANKS-1:0]            cmd_mask_o,
    output logic [ADDR_WIDTH-1:0]           cmd_addr_o,
    output logic                            wvalid_o,
    input  logic                            wready_i,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] wdata_o,
    input  logic                            rvalid_i,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] rdata_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [DATA_WIDTH-1:0]           out_data_o,
    output logic                            out_last_o
);

    localparam int BEAT_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BANKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_CMD,
        S_RD_WAIT,
        S_CLR,
        S_SEND,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ADDR_WIDTH:0]     nrows_q, nrows_d;
    logic [ADDR_WIDTH:0]     row_q, row_d;
    logic                    clear_q, clear_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic                    cmd_done_q, cmd_done_d;
    logic                    w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0]   buf_q [NUM_BANKS];
    logic                    buf_load;
    logic [ADDR_WIDTH:0]     row_inc;

    assign cmd_accum_en_o = 1'b0;
    assign cmd_mask_o     = '1;
    assign wdata_o        = '0;
    // Row counter is one bit wider than the address, so the sum wraps mod 2^ADDR_WIDTH.
    assign cmd_addr_o     = base_q + row_q[ADDR_WIDTH-1:0];
    assign out_data_o     = buf_q[beat_q];
    assign buf_load       = (state_q == S_RD_WAIT) && rvalid_i;
    assign row_inc        = row_q + (ADDR_WIDTH+1)'(1);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        nrows_d     = nrows_q;
        row_d       = row_q;
        clear_d     = clear_q;
        beat_d      = beat_q;
        cmd_done_d  = cmd_done_q;
        w_done_d    = w_done_q;
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
        cmd_valid_o = 1'b0;
        cmd_rw_o    = 1'b0;
        wvalid_o    = 1'b0;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    base_d  = base_addr_i;
                    nrows_d = num_rows_i;
                    clear_d = clear_en_i;
                    row_d   = '0;
                    state_d = (num_rows_i == '0) ? S_DONE : S_RD_CMD;
                end
            end
            S_RD_CMD: begin
                cmd_valid_o = 1'b1;
                if (cmd_ready_i) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (rvalid_i) begin
                    beat_d     = '0;
                    cmd_done_d = 1'b0;
                    w_done_d   = 1'b0;
                    state_d    = clear_q ? S_CLR : S_SEND;
                end
            end
            S_CLR: begin
                // Each channel drops its valid once its own handshake is seen.
                cmd_valid_o = ~cmd_done_q;
                cmd_rw_o    = 1'b1;
                wvalid_o    = ~w_done_q;
                cmd_done_d  = cmd_done_q | cmd_ready_i;
                w_done_d    = w_done_q | wready_i;
                if (cmd_done_d && w_done_d) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                out_valid_o = 1'b1;
                out_last_o  = (beat_q == LAST_BEAT) && (row_inc == nrows_q);
                if (out_ready_i) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        row_d   = row_inc;
                        state_d = (row_inc < nrows_q) ? S_RD_CMD : S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            nrows_q    <= '0;
            row_q      <= '0;
            clear_q    <= 1'b0;
            beat_q     <= '0;
            cmd_done_q <= 1'b0;
            w_done_q   <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                buf_q[b] <= '0;
            end
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            nrows_q    <= nrows_d;
            row_q      <= row_d;
            clear_q    <= clear_d;
            beat_q     <= beat_d;
            cmd_done_q <= cmd_done_d;
            w_done_q   <= w_done_d;
            if (buf_load) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    buf_q[b] <= rdata_i[b*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_accum_drain.sv
// ---------------------------------------------------------------------------
// tb_accum_drain
// Bench for accum_drain. A row-array model of the accumulator answers the
// DUT's commands with random read latency and random ready backpressure; a
// per-job expectation (command list and word list, built from the model
// contents when the job starts) is compared against every handshake.
// ---------------------------------------------------------------------------
module tb_accum_drain;

    localparam int NB = 4;
    localparam int DW = 64;
    localparam int AW = 9;
    localparam int RW = NB * DW;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            start_i;
    logic [AW-1:0]   base_addr_i;
    logic [AW:0]     num_rows_i;
    logic            clear_en_i;
    logic            busy_o;
    logic            done_o;
    logic            cmd_valid_o;
    logic            cmd_ready_i;
    logic            cmd_rw_o;
    logic            cmd_accum_en_o;
    logic [NB-1:0]   cmd_mask_o;
    logic [AW-1:0]   cmd_addr_o;
    logic            wvalid_o;
    logic            wready_i;
    logic [RW-1:0]   wdata_o;
    logic            rvalid_i;
    logic [RW-1:0]   rdata_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [DW-1:0]   out_data_o;
    logic            out_last_o;

    always #5 clk_i = ~clk_i;

    accum_drain #(.NUM_BANKS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .base_addr_i(base_addr_i), .num_rows_i(num_rows_i), .clear_en_i(clear_en_i),
        .busy_o(busy_o), .done_o(done_o),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_rw_o(cmd_rw_o),
        .cmd_accum_en_o(cmd_accum_en_o), .cmd_mask_o(cmd_mask_o), .cmd_addr_o(cmd_addr_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o),
        .rvalid_i(rvalid_i), .rdata_i(rdata_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_last_o(out_last_o)
    );

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
    } cmd_t;

    logic [RW-1:0] mem [512];
    cmd_t          exp_cmd[$];
    logic [DW:0]   exp_beat[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    bit            pend;
    int            lat_cnt;
    logic [AW-1:0] pend_addr;
    int            w_seen, w_exp;
    bit            expect_done;
    int            ready_pct;
    bit            abuse;
    bit            cmd_stall, w_stall, out_stall;
    logic          prev_rw;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] rnd_row();
        logic [RW-1:0] r;
        for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk_reset();
        chk("rst_busy",      64'(busy_o), 64'(0));
        chk("rst_done",      64'(done_o), 64'(0));
        chk("rst_cmd_valid", 64'(cmd_valid_o), 64'(0));
        chk("rst_wvalid",    64'(wvalid_o), 64'(0));
        chk("rst_out_valid", 64'(out_valid_o), 64'(0));
        chk("rst_out_last",  64'(out_last_o), 64'(0));
        chk("rst_cmd_rw",    64'(cmd_rw_o), 64'(0));
        chk("rst_accum_en",  64'(cmd_accum_en_o), 64'(0));
        chk("rst_mask",      64'(cmd_mask_o), 64'(4'hF));
        chk("rst_cmd_addr",  64'(cmd_addr_o), 64'(0));
        chk("rst_wdata",     64'(|wdata_o), 64'(0));
        chk("rst_out_data",  out_data_o, 64'(0));
    endtask

    // One clock: observe at the falling edge, then drive the inputs that the
    // next rising edge will sample and account for the handshakes it completes.
    task automatic step(input bit rst_now);
        cmd_t        e;
        logic [DW:0] b;
        @(negedge clk_i);
        cyc++;
        chk("done", 64'(done_o), 64'(expect_done));
        if (expect_done) chk("busy_in_done", 64'(busy_o), 64'(1));
        expect_done = 1'b0;
        if (cmd_stall) begin
            chk("cmd_valid_hold", 64'(cmd_valid_o), 64'(1));
            chk("cmd_rw_hold", 64'(cmd_rw_o), 64'(prev_rw));
            chk("cmd_addr_hold", 64'(cmd_addr_o), 64'(prev_addr));
        end
        if (w_stall) chk("wvalid_hold", 64'(wvalid_o), 64'(1));
        if (out_stall) begin
            chk("out_valid_hold", 64'(out_valid_o), 64'(1));
            chk("out_data_hold", out_data_o, prev_data);
            chk("out_last_hold", 64'(out_last_o), 64'(prev_last));
        end
        if (rst_now) begin
            rst_i = 1'b1; start_i = 1'b0; rvalid_i = 1'b0;
            cmd_ready_i = 1'b0; wready_i = 1'b0; out_ready_i = 1'b0;
            pend = 1'b0; cmd_stall = 1'b0; w_stall = 1'b0; out_stall = 1'b0;
            return;
        end

        rvalid_i = 1'b0;
        rdata_i  = rnd_row();
        if (pend) begin
            if (lat_cnt == 0) begin
                rvalid_i = 1'b1;
                rdata_i  = mem[pend_addr];
                pend     = 1'b0;
            end else begin
                lat_cnt--;
            end
        end else if (ready_pct < 100 && $urandom_range(3) == 0) begin
            rvalid_i = 1'b1;   // stray return, must be ignored
        end

        cmd_ready_i = ($urandom_range(99) < ready_pct);
        wready_i    = ($urandom_range(99) < ready_pct);
        out_ready_i = ($urandom_range(99) < ready_pct);

        if (cmd_valid_o && cmd_ready_i) begin
            if (exp_cmd.size() == 0) begin
                chk("cmd_unexpected", 64'(exp_cmd.size()), 64'(1));
            end else begin
                e = exp_cmd.pop_front();
                chk("cmd_rw", 64'(cmd_rw_o), 64'(e.rw));
                chk("cmd_addr", 64'(cmd_addr_o), 64'(e.addr));
                chk("cmd_accum_en", 64'(cmd_accum_en_o), 64'(0));
                chk("cmd_mask", 64'(cmd_mask_o), 64'(4'hF));
                if (!e.rw) begin
                    pend      = 1'b1;
                    pend_addr = e.addr;
                    lat_cnt   = (ready_pct == 100) ? 0 : int'($urandom_range(7));
                end else begin
                    mem[e.addr] = '0;
                end
            end
        end
        if (wvalid_o && wready_i) begin
            w_seen++;
            chk("wdata_zero", 64'(|wdata_o), 64'(0));
        end
        if (out_valid_o && out_ready_i) begin
            if (exp_beat.size() == 0) begin
                chk("beat_unexpected", 64'(exp_beat.size()), 64'(1));
            end else begin
                b = exp_beat.pop_front();
                chk("out_data", out_data_o, b[DW-1:0]);
                chk("out_last", 64'(out_last_o), 64'(b[DW]));
                if (b[DW]) expect_done = 1'b1;
            end
        end

        cmd_stall = cmd_valid_o && !cmd_ready_i;
        w_stall   = wvalid_o && !wready_i;
        out_stall = out_valid_o && !out_ready_i;
        prev_rw   = cmd_rw_o;
        prev_addr = cmd_addr_o;
        prev_data = out_data_o;
        prev_last = out_last_o;

        start_i = 1'b0;
        if (abuse && busy_o && $urandom_range(7) == 0) begin
            start_i     = 1'b1;
            base_addr_i = AW'($urandom_range(511));
            num_rows_i  = (AW+1)'($urandom_range(512));
            clear_en_i  = 1'($urandom_range(1));
        end
    endtask

    task automatic launch(input int base, input int n, input bit clr, input int pct, input bit ab,
                          output int c0);
        logic [AW-1:0] a;
        exp_cmd.delete();
        exp_beat.delete();
        for (int r = 0; r < n; r++) begin
            a = AW'(base + r);
            exp_cmd.push_back('{rw: 1'b0, addr: a});
            for (int k = 0; k < NB; k++)
                exp_beat.push_back({(r == n - 1 && k == NB - 1), mem[a][k*DW +: DW]});
            if (clr) exp_cmd.push_back('{rw: 1'b1, addr: a});
        end
        w_exp     = clr ? n : 0;
        w_seen    = 0;
        ready_pct = pct;
        abuse     = 1'b0;
        step(1'b0);
        start_i     = 1'b1;
        base_addr_i = AW'(base);
        num_rows_i  = (AW+1)'(n);
        clear_en_i  = clr;
        c0          = cyc;
        if (n == 0) expect_done = 1'b1;
        step(1'b0);
        abuse = ab;
        if (n > 0) chk("cmd_valid_after_start", 64'(cmd_valid_o), 64'(1));
    endtask

    task automatic run_job(input int base, input int n, input bit clr, input int pct, input bit ab);
        int c0;
        bit seen;
        launch(base, n, clr, pct, ab, c0);
        seen = (n == 0) ? done_o : 1'b0;
        for (int k = 0; k < 6000 && !seen; k++) begin
            step(1'b0);
            seen = done_o;
        end
        chk("job_done_seen", 64'(seen), 64'(1));
        if (pct == 100 && !ab)
            chk("job_cycles", 64'(cyc - c0), 64'(n == 0 ? 1 : n * (6 + int'(clr)) + 1));
        chk("cmds_left", 64'(exp_cmd.size()), 64'(0));
        chk("beats_left", 64'(exp_beat.size()), 64'(0));
        chk("wdata_beats", 64'(w_seen), 64'(w_exp));
        abuse = 1'b0;
        step(1'b0);
        chk("busy_after_done", 64'(busy_o), 64'(0));
    endtask

    initial begin
        int  c0;
        bit  found;
        rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; num_rows_i = '0; clear_en_i = 1'b0;
        cmd_ready_i = 1'b0; wready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; out_ready_i = 1'b0;
        pend = 1'b0; lat_cnt = 0; pend_addr = '0; w_seen = 0; w_exp = 0; expect_done = 1'b0;
        ready_pct = 100; abuse = 1'b0; cmd_stall = 1'b0; w_stall = 1'b0; out_stall = 1'b0;
        prev_rw = 1'b0; prev_addr = '0; prev_data = '0; prev_last = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = rnd_row();

        repeat (2) @(negedge clk_i);
        chk_reset();
        rst_i = 1'b0;

        mem[0] = {64'd4, 64'd3, 64'd2, 64'd1};
        mem[1] = {64'd8, 64'd7, 64'd6, 64'd5};
        run_job(0, 2, 1'b0, 100, 1'b0);

        run_job(5, 1, 1'b1, 100, 1'b0);
        run_job(5, 1, 1'b0, 100, 1'b0);

        run_job(510, 4, 1'b0, 100, 1'b0);
        run_job(510, 4, 1'b1, 60, 1'b0);
        run_job(123, 0, 1'b0, 100, 1'b0);

        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < 512; i++) if ($urandom_range(3) == 0) mem[i] = rnd_row();
            run_job(int'($urandom_range(511)), int'($urandom_range(1, 6)), 1'($urandom_range(1)),
                    int'($urandom_range(30, 90)), 1'b1);
        end

        launch(200, 3, 1'b1, 60, 1'b0, c0);
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            step(1'b0);
            found = out_valid_o;
        end
        chk("reached_send", 64'(found), 64'(1));
        step(1'b1);
        @(negedge clk_i);
        chk_reset();
        rst_i = 1'b0;
        rvalid_i = 1'b1;
        rdata_i = rnd_row();
        exp_cmd.delete();
        exp_beat.delete();
        expect_done = 1'b0;
        @(negedge clk_i);
        rvalid_i = 1'b0;
        chk("stray_busy", 64'(busy_o), 64'(0));
        chk("stray_out_valid", 64'(out_valid_o), 64'(0));
        chk("stray_cmd_valid", 64'(cmd_valid_o), 64'(0));

        run_job(200, 3, 1'b0, 100, 1'b0);
        run_job(int'($urandom_range(511)), 5, 1'b1, 50, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
